// File: rtl/fifo_stream_adapter_if.sv
// Bundle between the FIFO read port, the stream sink and the fifo_stream_adapter.
//   fifo_empty / fifo_data : FIFO status and read data (data valid the cycle after a read)
//   fifo_r_en              : FIFO read enable, driven by the adapter
//   m_valid / m_ready      : stream handshake towards the sink
//   m_data                 : stream payload (buffer head)
//   buf_count              : words currently held in the prefetch buffer
// Modports: master = adapter side, slave = FIFO/sink side.
interface fifo_stream_adapter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            buf_count;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_r_en, m_valid, m_data, buf_count
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_r_en, m_valid, m_data, buf_count
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Converts a FIFO read port (r_en/empty, one-cycle read latency) into a
// valid/ready stream through a 3-entry prefetch ring buffer.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of buffered and in-flight data
//   bus    : fifo_stream_adapter_if.master (FIFO read side + stream side + buf_count)
module fifo_stream_adapter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  fifo_stream_adapter_if.master  bus
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned OCC_W = 3;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      count_q;
  logic                  inflight_q;
  logic                  valid_q;

  logic [OCC_W-1:0]      occ;
  logic                  capture;
  logic                  pop;
  logic [PTR_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] head;

  // Ring pointer increment with wrap 2 -> 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Held words plus the word in flight; reads are only issued while a slot is guaranteed.
  always_comb begin
    occ        = {1'b0, count_q} + OCC_W'(inflight_q);
    capture    = inflight_q & ~flush;
    pop        = valid_q & bus.m_ready;
    count_next = count_q + PTR_W'(capture) - PTR_W'(pop);
  end

  // Read enable depends only on registered state and the FIFO flag (no m_ready path).
  assign bus.fifo_r_en = rst_n & ~flush & ~bus.fifo_empty & (occ < OCC_W'(DEPTH));

  // Head-of-buffer select.
  always_comb begin
    head = mem_q[0];
    case (rd_ptr_q)
      2'd1:    head = mem_q[1];
      2'd2:    head = mem_q[2];
      default: ;
    endcase
  end

  assign bus.m_valid   = valid_q;
  assign bus.m_data    = head;
  assign bus.buf_count = count_q;

  // Buffer state; valid_q tracks (count != 0) as a flop of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      inflight_q <= bus.fifo_r_en;
      for (int i = 0; i < DEPTH; i++) begin
        if (capture && (wr_ptr_q == PTR_W'(i))) mem_q[i] <= bus.fifo_data;
      end
      if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_next;
      valid_q <= (count_next != '0);
    end
  end

  // Held plus in-flight words must never exceed the buffer depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) occ <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
module tb_fifo_stream_adapter;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  fifo_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_adapter #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int  reads_total = 0;
  int  retired = 0;
  int  inflight_m = 0;
  logic rd_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired at %0t", name, $time);
  endtask

  // Behavioural FIFO: a read accepted at an edge shows its word after that edge.
  always @(posedge clk) begin
    inflight_m = 0;
    if (rst_n && rd_req && fifo_q.size() > 0) begin
      bus.fifo_data <= fifo_q.pop_front();
      reads_total = reads_total + 1;
      inflight_m = 1;
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor / scoreboard, sampled mid-cycle.
  logic          pv = 1'b0, pr = 1'b0, pf = 1'b0;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin
    int held;
    logic [DW-1:0] e;
    rd_req = bus.fifo_r_en;
    if (!rst_n) begin
      retired = reads_total;
      pv = 1'b0;
    end else begin
      held = reads_total - retired - inflight_m;
      chk("buf_count_model", int'(bus.buf_count), held);
      chk("m_valid_model", int'(bus.m_valid), int'(held != 0));
      if (bus.fifo_empty) chk("no_read_when_empty", int'(bus.fifo_r_en), 0);
      if (flush) chk("no_read_in_flush", int'(bus.fifo_r_en), 0);
      if (pv && !pr && !pf) begin
        chk("stall_valid_held", int'(bus.m_valid), 1);
        chk("stall_data_held", int'(bus.m_data), int'(pd));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h expected=none at %0t", bus.m_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", int'(bus.m_data), int'(e));
        end
        retired = retired + 1;
      end
      if (flush) begin
        while (retired < reads_total) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          retired = retired + 1;
        end
      end
      pv = bus.m_valid; pr = bus.m_ready; pf = flush; pd = bus.m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_count(input logic [1:0] target, input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      if (bus.buf_count == target) break;
      step(1);
    end
    if (k == 50) fail_now(name);
  endtask

  task automatic drain(input string name);
    int k;
    bus.m_ready = 1'b1;
    flush = 1'b0;
    for (k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.m_valid && !bus.fifo_r_en) break;
      step(1);
    end
    if (k == 300) fail_now(name);
    step(2);
    chk({name, "_idle"}, int'(bus.m_valid), 0);
  endtask

  initial begin
    int base, pulses, k;
    bus.m_ready = 1'b1;
    step(3);
    chk("reset_m_valid", int'(bus.m_valid), 0);
    chk("reset_buf_count", int'(bus.buf_count), 0);
    chk("reset_r_en", int'(bus.fifo_r_en), 0);
    chk("reset_m_data", int'(bus.m_data), 0);

    // Start-up from reset with 8 words queued, sink always ready.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("startup_no_valid_yet", int'(bus.m_valid), 0);
    step(1);
    for (int i = 1; i <= 8; i++) begin
      chk("burst_valid", int'(bus.m_valid), 1);
      chk("burst_data", int'(bus.m_data), i);
      step(1);
    end
    chk("burst_end_valid", int'(bus.m_valid), 0);
    chk("burst_end_r_en", int'(bus.fifo_r_en), 0);

    // Backpressure: exactly three reads, head held.
    bus.m_ready = 1'b0;
    base = reads_total;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    step(12);
    chk("bp_reads", reads_total - base, 3);
    chk("bp_buf_count", int'(bus.buf_count), 3);
    chk("bp_head", int'(bus.m_data), 1);
    chk("bp_fifo_left", fifo_q.size(), 5);
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("bp_drain_valid", int'(bus.m_valid), 1);
      chk("bp_drain_data", int'(bus.m_data), i);
      step(1);
    end
    drain("bp_drain");

    // Toggling ready over 16 words, wraps the pointers several times.
    for (int i = 1; i <= 16; i++) push(DW'(i));
    for (k = 0; k < 200; k++) begin
      bus.m_ready = ~bus.m_ready;
      if (exp_q.size() == 0 && !bus.m_valid) break;
      step(1);
    end
    if (k == 200) fail_now("toggle_drain");
    drain("toggle");

    // Flush with two held words and one in flight.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(8'h20 + i));
    wait_count(2'd2, "flush_setup");
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_buf_count", int'(bus.buf_count), 0);
    chk("flush_m_valid", int'(bus.m_valid), 0);
    chk("flush_fifo_left", fifo_q.size(), 5);
    bus.m_ready = 1'b1;
    for (k = 0; k < 20; k++) begin
      if (bus.m_valid) break;
      step(1);
    end
    if (k == 20) fail_now("flush_resume");
    chk("flush_resume_word", int'(bus.m_data), 8'h24);
    drain("flush");

    // Asynchronous reset with a full buffer.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(8'h40 + i));
    wait_count(2'd3, "areset_setup");
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_m_valid", int'(bus.m_valid), 0);
    chk("areset_m_data", int'(bus.m_data), 0);
    chk("areset_buf_count", int'(bus.buf_count), 0);
    chk("areset_r_en", int'(bus.fifo_r_en), 0);
    fifo_q.delete();
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    step(1);

    // Single word, sink ready: r_en in the cycle empty falls, one valid pulse.
    bus.m_ready = 1'b1;
    push(8'h01);
    step(1);
    chk("single_r_en", int'(bus.fifo_r_en), 1);
    chk("single_valid_early", int'(bus.m_valid), 0);
    step(1);
    chk("single_valid_read_edge", int'(bus.m_valid), 0);
    step(1);
    chk("single_valid", int'(bus.m_valid), 1);
    chk("single_data", int'(bus.m_data), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.m_valid) pulses++;
    end
    chk("single_extra_pulses", pulses, 0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0) push(DW'($urandom_range(0, 255)));
      step(1);
    end
    flush = 1'b0;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end
endmodule
